// File: rtl/whirlpool_core_arbiter_if.sv
// Bus bundle between the lane controllers, the shared Whirlpool core and the arbiter.
// The arbiter connects through the slave modport; the lane/core side uses master.
interface whirlpool_core_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]     i_req;
    logic [NUM_REQ*512-1:0] i_req_data;
    logic [NUM_REQ*512-1:0] i_req_key;
    logic [NUM_REQ-1:0]     o_req_ack;
    logic                   o_core_init;
    logic [511:0]           o_core_data;
    logic [511:0]           o_core_key;
    logic                   i_core_valid;
    logic [511:0]           i_core_hash;
    logic                   o_rsp_valid;
    logic [ID_W-1:0]        o_rsp_id;
    logic [511:0]           o_rsp_hash;
    logic                   o_rsp_err;
    logic                   i_rsp_ready;
    logic                   o_busy;

    modport slave (
        input  i_req, i_req_data, i_req_key, i_core_valid, i_core_hash, i_rsp_ready,
        output o_req_ack, o_core_init, o_core_data, o_core_key,
               o_rsp_valid, o_rsp_id, o_rsp_hash, o_rsp_err, o_busy
    );

    modport master (
        output i_req, i_req_data, i_req_key, i_core_valid, i_core_hash, i_rsp_ready,
        input  o_req_ack, o_core_init, o_core_data, o_core_key,
               o_rsp_valid, o_rsp_id, o_rsp_hash, o_rsp_err, o_busy
    );
endinterface

// File: rtl/whirlpool_core_arbiter.sv
// Round-robin arbiter sharing one Whirlpool core between NUM_REQ lanes, one job in flight.
// Optional watchdog abort on a silent core is enabled by defining WP_ARB_TIMEOUT_EN.
module whirlpool_core_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    whirlpool_core_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;

    state_t               r_state;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      r_winner;
    logic [NUM_REQ-1:0]   r_ack;
    logic                 r_init;
    logic [511:0]         r_core_data;
    logic [511:0]         r_core_key;
    logic                 r_rsp_valid;
    logic [ID_W-1:0]      r_rsp_id;
    logic [511:0]         r_rsp_hash;
    logic                 r_rsp_err;

    logic [511:0]         w_data_arr [NUM_REQ];
    logic [511:0]         w_key_arr  [NUM_REQ];
    logic                 w_found;
    logic [ID_W-1:0]      w_grant;
    logic [ID_W-1:0]      w_ptr_next;

`ifdef WP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]     r_cnt;
`endif

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
        assign w_data_arr[gi] = bus.i_req_data[gi*512 +: 512];
        assign w_key_arr[gi]  = bus.i_req_key[gi*512 +: 512];
    end

    function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
        int s;
        s = base + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // First requester at or above the pointer wins, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && bus.i_req[wrap_idx(int'(r_ptr), i)]) begin
                w_found = 1'b1;
                w_grant = wrap_idx(int'(r_ptr), i);
            end
        end
    end

    assign w_ptr_next = (int'(r_winner) == NUM_REQ - 1) ? '0 : r_winner + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= '0;
            r_winner    <= '0;
            r_ack       <= '0;
            r_init      <= 1'b0;
            r_core_data <= '0;
            r_core_key  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_hash  <= '0;
            r_rsp_err   <= 1'b0;
`ifdef WP_ARB_TIMEOUT_EN
            r_cnt       <= '0;
`endif
        end else begin
            r_ack  <= '0;
            r_init <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_core_data <= w_data_arr[w_grant];
                        r_core_key  <= w_key_arr[w_grant];
                        r_winner    <= w_grant;
                        r_ack       <= NUM_REQ'(1) << w_grant;
                        r_state     <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    r_init  <= 1'b1;
                    r_state <= WAIT;
`ifdef WP_ARB_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                end
                WAIT: begin
                    // Core valid takes priority over a watchdog expiry in the same cycle.
                    if (bus.i_core_valid) begin
                        r_rsp_hash  <= bus.i_core_hash;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_winner;
                        r_rsp_err   <= 1'b0;
                        r_state     <= RESP;
                    end
`ifdef WP_ARB_TIMEOUT_EN
                    else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_hash  <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_id    <= r_winner;
                        r_rsp_err   <= 1'b1;
                        r_state     <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_ptr       <= w_ptr_next;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_req_ack   = r_ack;
    assign bus.o_core_init = r_init;
    assign bus.o_core_data = r_core_data;
    assign bus.o_core_key  = r_core_key;
    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_id    = r_rsp_id;
    assign bus.o_rsp_hash  = r_rsp_hash;
    assign bus.o_busy      = (r_state != IDLE);
`ifdef WP_ARB_TIMEOUT_EN
    assign bus.o_rsp_err   = r_rsp_err;
`else
    assign bus.o_rsp_err   = 1'b0;
`endif
endmodule

// File: tb/tb_whirlpool_core_arbiter.sv
// Directed bench for whirlpool_core_arbiter: round-robin table plus multi-cycle corner sequences.
// Timeout checks run only when WP_ARB_TIMEOUT_EN is defined (watchdog set to 8 cycles).
module tb_whirlpool_core_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    whirlpool_core_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    whirlpool_core_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT_CYCLES(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [1:0] exp_id;
    } vec_t;
    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] onehot(input logic [1:0] id);
        logic [3:0] v;
        v = 4'b0001 << id;
        return 512'(v);
    endfunction

    task automatic load_slices();
        for (int k = 0; k < 4; k++) begin
            bus.i_req_data[k*512 +: 512] = 512'h1000 + 512'(k);
            bus.i_req_key[k*512 +: 512]  = 512'h2000 + 512'(k);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic run_job(input int n, input logic [3:0] req, input logic [1:0] exp_id);
        bus.i_req = req;
        tick();
        check("tbl_ack", 512'(bus.o_req_ack), onehot(exp_id));
        check("tbl_data", bus.o_core_data, 512'h1000 + 512'(exp_id));
        check("tbl_key", bus.o_core_key, 512'h2000 + 512'(exp_id));
        bus.i_req = '0;
        tick();
        check("tbl_init", 512'(bus.o_core_init), 512'd1);
        check("tbl_ack_clr", 512'(bus.o_req_ack), 512'd0);
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'hABC00 + 512'(exp_id);
        tick();
        bus.i_core_valid = 1'b0;
        check("tbl_rsp_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("tbl_rsp_id", 512'(bus.o_rsp_id), 512'(exp_id));
        check("tbl_rsp_hash", bus.o_rsp_hash, 512'hABC00 + 512'(exp_id));
        check("tbl_rsp_err", 512'(bus.o_rsp_err), 512'd0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("tbl_rsp_done", 512'(bus.o_rsp_valid), 512'd0);
        check("tbl_busy", 512'(bus.o_busy), 512'd0);
        $display("job %0d req=%b grant=%0d hash=%0h", n, req, exp_id, bus.o_rsp_hash[19:0]);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ack"}, 512'(bus.o_req_ack), 512'd0);
        check({tag, "_init"}, 512'(bus.o_core_init), 512'd0);
        check({tag, "_data"}, bus.o_core_data, 512'd0);
        check({tag, "_key"}, bus.o_core_key, 512'd0);
        check({tag, "_rsp_valid"}, 512'(bus.o_rsp_valid), 512'd0);
        check({tag, "_rsp_id"}, 512'(bus.o_rsp_id), 512'd0);
        check({tag, "_rsp_hash"}, bus.o_rsp_hash, 512'd0);
        check({tag, "_rsp_err"}, 512'(bus.o_rsp_err), 512'd0);
        check({tag, "_busy"}, 512'(bus.o_busy), 512'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'b1111, 2'd0};
        vecs[1]  = '{4'b1111, 2'd1};
        vecs[2]  = '{4'b1111, 2'd2};
        vecs[3]  = '{4'b1111, 2'd3};
        vecs[4]  = '{4'b1111, 2'd0};
        vecs[5]  = '{4'b0001, 2'd0};
        vecs[6]  = '{4'b1100, 2'd2};
        vecs[7]  = '{4'b0110, 2'd1};
        vecs[8]  = '{4'b1001, 2'd3};
        vecs[9]  = '{4'b1000, 2'd3};
        vecs[10] = '{4'b0110, 2'd1};

        bus.i_req        = '0;
        bus.i_req_data   = '0;
        bus.i_req_key    = '0;
        bus.i_core_valid = 1'b0;
        bus.i_core_hash  = '0;
        bus.i_rsp_ready  = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;

        // Single request, exact latencies.
        bus.i_req_data[511:0] = 512'h1;
        bus.i_req_key[511:0]  = 512'h2;
        bus.i_req = 4'b0001;
        tick();
        check("single_ack", 512'(bus.o_req_ack), 512'd1);
        check("single_init_early", 512'(bus.o_core_init), 512'd0);
        check("single_data", bus.o_core_data, 512'h1);
        check("single_key", bus.o_core_key, 512'h2);
        bus.i_req = '0;
        tick();
        check("single_init", 512'(bus.o_core_init), 512'd1);
        check("single_ack_clr", 512'(bus.o_req_ack), 512'd0);
        tick();
        check("single_init_clr", 512'(bus.o_core_init), 512'd0);
        check("single_busy", 512'(bus.o_busy), 512'd1);
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'hABCD;
        tick();
        bus.i_core_valid = 1'b0;
        check("single_rsp_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("single_rsp_id", 512'(bus.o_rsp_id), 512'd0);
        check("single_rsp_hash", bus.o_rsp_hash, 512'hABCD);
        check("single_rsp_err", 512'(bus.o_rsp_err), 512'd0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("single_rsp_done", 512'(bus.o_rsp_valid), 512'd0);
        $display("single job done hash=%0h", bus.o_rsp_hash[15:0]);

        // Round-robin table from a fresh pointer.
        load_slices();
        do_reset();
        for (int v = 0; v < 11; v++) run_job(v, vecs[v].req, vecs[v].exp_id);

        // Backpressure: pointer is now 2.
        bus.i_req = 4'b0100;
        tick();
        check("bp_ack", 512'(bus.o_req_ack), onehot(2'd2));
        bus.i_req = '0;
        tick();
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'h5555;
        tick();
        bus.i_core_valid = 1'b0;
        bus.i_req = 4'b0010;
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 512'(bus.o_rsp_valid), 512'd1);
            check("bp_id", 512'(bus.o_rsp_id), 512'd2);
            check("bp_hash", bus.o_rsp_hash, 512'h5555);
            check("bp_no_ack", 512'(bus.o_req_ack), 512'd0);
            tick();
        end
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("bp_handshake", 512'(bus.o_rsp_valid), 512'd0);
        check("bp_ack_gap", 512'(bus.o_req_ack), 512'd0);
        tick();
        check("bp_ack_after", 512'(bus.o_req_ack), onehot(2'd1));
        check("bp_data_after", bus.o_core_data, 512'h1001);
        $display("backpressure released, lane 1 acked");
        bus.i_req = '0;
        tick();
        check("stale_init", 512'(bus.o_core_init), 512'd1);

        // Stale valid: held high across RESP, IDLE and LAUNCH of the next job.
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'hDEAD;
        tick();
        check("stale_rsp1_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("stale_rsp1_hash", bus.o_rsp_hash, 512'hDEAD);
        check("stale_rsp1_id", 512'(bus.o_rsp_id), 512'd1);
        bus.i_req = 4'b0001;
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        check("stale_resp_edge", 512'(bus.o_rsp_valid), 512'd0);
        tick();
        check("stale_idle_ack", 512'(bus.o_req_ack), onehot(2'd0));
        check("stale_idle_valid", 512'(bus.o_rsp_valid), 512'd0);
        bus.i_req = '0;
        bus.i_core_hash = 512'hBEEF;
        tick();
        check("stale_launch_valid", 512'(bus.o_rsp_valid), 512'd0);
        check("stale_launch_init", 512'(bus.o_core_init), 512'd1);
        tick();
        bus.i_core_valid = 1'b0;
        check("stale_wait_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("stale_wait_hash", bus.o_rsp_hash, 512'hBEEF);
        check("stale_wait_id", 512'(bus.o_rsp_id), 512'd0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        $display("stale valid job done hash=%0h", bus.o_rsp_hash[15:0]);

        // Reset in WAIT; pointer is 1 so lane 2 wins.
        bus.i_req = 4'b0100;
        tick();
        check("rst_job_ack", 512'(bus.o_req_ack), onehot(2'd2));
        bus.i_req = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'h1234;
        tick();
        bus.i_core_valid = 1'b0;
        tick();
        check("midrst_no_rsp", 512'(bus.o_rsp_valid), 512'd0);
        check("midrst_idle", 512'(bus.o_busy), 512'd0);
        bus.i_req = 4'b1111;
        tick();
        check("midrst_ptr0", 512'(bus.o_req_ack), onehot(2'd0));
        bus.i_req = '0;
        tick();
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'h7777;
        tick();
        bus.i_core_valid = 1'b0;
        check("midrst_next_id", 512'(bus.o_rsp_id), 512'd0);
        check("midrst_next_hash", bus.o_rsp_hash, 512'h7777);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        $display("reset mid-job recovered");

`ifdef WP_ARB_TIMEOUT_EN
        // Silent core: abort after 8 WAIT cycles. Pointer is 1.
        bus.i_req = 4'b0010;
        tick();
        check("to_ack", 512'(bus.o_req_ack), onehot(2'd1));
        bus.i_req = '0;
        tick();
        for (int c = 0; c < 7; c++) begin
            tick();
            check("to_early", 512'(bus.o_rsp_valid), 512'd0);
        end
        tick();
        check("to_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("to_err", 512'(bus.o_rsp_err), 512'd1);
        check("to_hash", bus.o_rsp_hash, 512'd0);
        check("to_id", 512'(bus.o_rsp_id), 512'd1);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        $display("timeout job aborted id=1");
        // Valid arriving on the limit cycle wins.
        bus.i_req = 4'b0100;
        tick();
        bus.i_req = '0;
        tick();
        for (int c = 0; c < 7; c++) begin
            tick();
            check("tv_early", 512'(bus.o_rsp_valid), 512'd0);
        end
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'h9999;
        tick();
        bus.i_core_valid = 1'b0;
        check("tv_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("tv_err", 512'(bus.o_rsp_err), 512'd0);
        check("tv_hash", bus.o_rsp_hash, 512'h9999);
        check("tv_id", 512'(bus.o_rsp_id), 512'd2);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        $display("limit-cycle valid job done id=2");
`else
        // Without the watchdog, WAIT persists well beyond any limit.
        bus.i_req = 4'b0010;
        tick();
        bus.i_req = '0;
        tick();
        for (int c = 0; c < 80; c++) tick();
        check("nowd_still_wait", 512'(bus.o_rsp_valid), 512'd0);
        check("nowd_busy", 512'(bus.o_busy), 512'd1);
        bus.i_core_valid = 1'b1;
        bus.i_core_hash  = 512'h4242;
        tick();
        bus.i_core_valid = 1'b0;
        check("nowd_valid", 512'(bus.o_rsp_valid), 512'd1);
        check("nowd_hash", bus.o_rsp_hash, 512'h4242);
        check("nowd_err", 512'(bus.o_rsp_err), 512'd0);
        bus.i_rsp_ready = 1'b1;
        tick();
        bus.i_rsp_ready = 1'b0;
        $display("long-wait job done id=1");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/whirlpool_core_arbiter.md
Name: whirlpool_core_arbiter

Overview:
- Shares one Whirlpool compression core between NUM_REQ requesters, e.g. parallel PBKDF2-HMAC lanes.
- Arbitrates round-robin and latches the winner's data block and key.
- Launches the core with a one-cycle init pulse, waits for the hash, then returns it on a shared response channel tagged with the requester ID.
- Only one job is in flight at a time; the block sits between the lane controllers and the core.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with WP_ARB_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_req  in  NUM_REQ  per-requester request; held high until acked.
- i_req_data  in  NUM_REQ*512  per-requester data block; slice k = bits [512k+511:512k].
- i_req_key  in  NUM_REQ*512  per-requester key, same slicing.
- o_req_ack  out  NUM_REQ  one-cycle pulse: request accepted, data/key captured.
- o_core_init  out  1  one-cycle start pulse to core.
- o_core_data  out  512  latched data to core.
- o_core_key  out  512  latched key to core.
- i_core_valid  in  1  core hash valid.
- i_core_hash  in  512  core hash output.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  ID_W  requester owning the response.
- o_rsp_hash  out  512  hash result.
- o_rsp_err  out  1  response is a timeout abort (always 0 when the macro is off).
- i_rsp_ready  in  1  response consumer ready.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst high at clock edge): all outputs 0, state IDLE, round-robin pointer 0, latched data/key 0. Reset mid-job abandons the job silently: no ack, no response. Any later i_core_valid is ignored until a new LAUNCH.
- States: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - If i_req is nonzero, select the first set bit scanning from the pointer upward, wrapping modulo NUM_REQ.
  - On that edge: latch o_core_data/o_core_key from the winner's slice, latch the winner ID, pulse o_req_ack[winner] for exactly one cycle, go to LAUNCH.
  - If i_req is zero, stay in IDLE.
- LAUNCH: o_core_init = 1 for exactly this one cycle; next state WAIT. o_core_data/key stay stable from the IDLE capture until the next IDLE capture.
- WAIT:
  - First cycle with i_core_valid = 1: capture i_core_hash into o_rsp_hash, set o_rsp_valid = 1, set o_rsp_id to the winner, go to RESP.
  - i_core_valid is ignored in every state except WAIT, including level-held valid left over from a previous job.
- RESP:
  - o_rsp_valid/o_rsp_id/o_rsp_hash hold stable until i_rsp_ready = 1.
  - On the handshake edge: o_rsp_valid = 0, pointer = (winner+1) mod NUM_REQ, go to IDLE.
  - i_rsp_ready high while o_rsp_valid is low has no effect.
- Latency:
  - Request seen to ack: 1 edge.
  - Ack to o_core_init: 1 cycle.
  - i_core_valid to o_rsp_valid: 1 cycle.
  - Minimum gap between back-to-back jobs: the response handshake edge, then one IDLE cycle.
- Fairness: a requester continuously requesting is served at least once every NUM_REQ jobs. Requests arriving while busy wait and are not acked.
- A requester dropping i_req before ack is legal and simply not served.

Optional Feature:
- Macro WP_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES with no i_core_valid: go to RESP with o_rsp_err = 1, o_rsp_hash = 0, o_rsp_id = winner.
  - If i_core_valid is 1 in the same cycle the count reaches TIMEOUT_CYCLES, valid wins and o_rsp_err = 0.
- Not defined: no counter is built, o_rsp_err is tied to 0, and WAIT lasts indefinitely.

Test Plan:
- Single request: i_req=0b0001, data=512'h1, key=512'h2.
  - Expect: ack[0] on edge 1, o_core_init on the next cycle, o_core_data=1, o_core_key=2.
  - Core returns valid with hash 512'hABCD: expect o_rsp_valid next cycle, id=0, hash=ABCD, err=0.
- Round-robin: i_req=0b1111 held, i_rsp_ready=1, each request re-asserted after its ack.
  - Expect grant order 0,1,2,3,0 over five jobs.
- Backpressure: i_rsp_ready=0 for 10 cycles.
  - Expect o_rsp_valid/id/hash stable and no new ack while i_req=0b0010 is pending.
  - Release ready: expect ack[1] one cycle after the handshake.
- Stale valid: hold i_core_valid=1 with hash 0xDEAD through RESP and IDLE into LAUNCH of the next job.
  - Expect it ignored until WAIT.
  - Expect the first WAIT cycle to capture the hash on the current i_core_hash value.
- Reset mid-job: assert i_rst during WAIT.
  - Expect all outputs 0 next cycle, state IDLE, pointer 0.
  - A later i_core_valid pulse must produce no response.
- Timeout (macro on, TIMEOUT_CYCLES=8): no core valid after launch.
  - Expect o_rsp_valid with err=1, hash=0, 8 cycles after entering WAIT.
  - Valid on exactly cycle 8: expect err=0 with the core hash.
